// File: rtl/exec_controller_if.sv
// exec_controller_if
//   Memory handshake bundle between the execution controller and memory.
//   mem_req  : request, held from state entry until the ack cycle
//   mem_we   : write request (store only), stable while mem_req is high
//   addr_sel : 0 = PC, 1 = ALU result, stable while mem_req is high
//   mem_ack  : single-cycle completion pulse from memory
//   master = controller side, slave = memory side.
interface exec_controller_if;
   logic mem_req;
   logic mem_we;
   logic addr_sel;
   logic mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output addr_sel,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  addr_sel,
      output mem_ack
   );
endinterface

// File: rtl/exec_controller.sv
// exec_controller
//   Multi-cycle control FSM: FETCH / DECODE / EXECUTE / MEM / WRITEBACK.
//   Inputs : clk, reset_n (async, active low), start, id (decoded instruction
//            ID, legal 1..26), rs (rs[1:0] = syscall function), br_taken,
//            mem (handshake interface, master side).
//   Outputs: ir_load, alu_op, pc_en, pc_sel, reg_we, wb_sel, display_en,
//            halted, fault, cycle_cnt, instr_cnt.
//   All control outputs decode combinationally from the state register and
//   the current id / rs / br_taken / mem_ack; only the state, the memory wait
//   counter and the two statistics counters are registered.
module exec_controller #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [31:0]             id,
   input  logic [31:0]             rs,
   input  logic                    br_taken,
   exec_controller_if.master       mem,
   output logic                    ir_load,
   output logic [4:0]              alu_op,
   output logic                    pc_en,
   output logic [1:0]              pc_sel,
   output logic                    reg_we,
   output logic [1:0]              wb_sel,
   output logic                    display_en,
   output logic                    halted,
   output logic                    fault,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [CNT_W-1:0]        instr_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   logic              w_retire;
   logic              w_timeout;
   logic              w_busy;
   logic              w_id_legal;
   logic              w_unused_rs;

   assign w_unused_rs = ^rs[31:2];
   assign w_id_legal  = (id != 32'd0) && (id <= 32'd26);
   assign w_busy      = (r_state == FETCH) || (r_state == DECODE) || (r_state == EXECUTE) ||
                        (r_state == MEM) || (r_state == WRITEBACK);
   // Wait count reaching its last slot with no ack in this cycle means
   // MEM_TIMEOUT request cycles have passed without an acknowledge.
   assign w_timeout   = (r_wait == WAIT_LAST) && !mem.mem_ack;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (start) w_next = FETCH;
         FETCH: begin
            if (mem.mem_ack)    w_next = DECODE;
            else if (w_timeout) w_next = FAULT;
         end
         DECODE:    w_next = w_id_legal ? EXECUTE : FAULT;
         EXECUTE: begin
            if (id inside {[32'd1:32'd12], 32'd24, 32'd25}) w_next = WRITEBACK;
            else if (id inside {32'd13, 32'd14})            w_next = MEM;
            else if (id inside {[32'd15:32'd23]})           w_next = FETCH;
            else if (id == 32'd26)                          w_next = (rs[1:0] == 2'd2) ? HALT : FETCH;
            else                                            w_next = FAULT;
         end
         MEM: begin
            if (mem.mem_ack)    w_next = (id == 32'd13) ? WRITEBACK : FETCH;
            else if (w_timeout) w_next = FAULT;
         end
         WRITEBACK: w_next = FETCH;
         HALT:      w_next = HALT;
         FAULT:     w_next = FAULT;
         default:   w_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      mem.mem_req  = 1'b0;
      mem.mem_we   = 1'b0;
      mem.addr_sel = 1'b0;
      ir_load      = 1'b0;
      alu_op       = '0;
      pc_en        = 1'b0;
      pc_sel       = 2'd0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      display_en   = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         FETCH: begin
            mem.mem_req = 1'b1;
            ir_load     = mem.mem_ack;
         end
         EXECUTE: begin
            alu_op = id[4:0];
            if (id inside {[32'd15:32'd20]}) begin
               pc_en    = 1'b1;
               pc_sel   = br_taken ? 2'd1 : 2'd0;
               w_retire = 1'b1;
            end else if (id == 32'd21) begin
               pc_en    = 1'b1;
               pc_sel   = 2'd2;
               w_retire = 1'b1;
            end else if (id == 32'd22) begin
               pc_en    = 1'b1;
               pc_sel   = 2'd3;
               w_retire = 1'b1;
            end else if (id == 32'd23) begin
               pc_en    = 1'b1;
               pc_sel   = 2'd2;
               reg_we   = 1'b1;
               wb_sel   = 2'd2;
               w_retire = 1'b1;
            end else if (id == 32'd26) begin
               // Syscall halt retires without touching the PC.
               w_retire   = 1'b1;
               pc_en      = (rs[1:0] != 2'd2);
               display_en = (rs[1:0] == 2'd1);
            end
         end
         MEM: begin
            mem.mem_req  = 1'b1;
            mem.addr_sel = 1'b1;
            mem.mem_we   = (id == 32'd14);
            if (mem.mem_ack && (id == 32'd14)) begin
               pc_en    = 1'b1;
               w_retire = 1'b1;
            end
         end
         WRITEBACK: begin
            reg_we   = 1'b1;
            wb_sel   = (id == 32'd13) ? 2'd1 : 2'd0;
            pc_en    = 1'b1;
            w_retire = 1'b1;
         end
         HALT:  halted = 1'b1;
         FAULT: begin
            halted = 1'b1;
            fault  = 1'b1;
         end
         default: ;
      endcase
   end

   // Memory wait counter: restarts outside the request states and on ack, so
   // every FETCH/MEM entry begins at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wait <= '0;
      end else if (((r_state == FETCH) || (r_state == MEM)) && !mem.mem_ack) begin
         r_wait <= r_wait + WAIT_W'(1);
      end else begin
         r_wait <= '0;
      end
   end

   // Statistics counters, wrapping naturally
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (w_busy)   cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (w_retire) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule
